// File: rtl/present_core_pio_status_in.sv
// Avalon-MM status input PIO: 2-FF synced inputs, sticky edge capture, maskable irq.
// Ports: clk, reset_n, address/chipselect/write_n/writedata/readdata (slave), in_port, irq.
module present_core_pio_status_in #(
  parameter int               WIDTH     = 32,
  parameter int               EDGE_TYPE = 0,
  parameter int               IRQ_TYPE  = 1,
  parameter logic [WIDTH-1:0] MASK_RST  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] d_prev;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edges;
  logic [WIDTH-1:0] clr;
  logic [31:0]      rd_mux;
  logic             wr;
  logic             irq_next;

  assign wr = chipselect & ~write_n;

  always_comb begin
    edges = '0;
    case (EDGE_TYPE)
      0:       edges = s2 & ~d_prev;
      1:       edges = ~s2 & d_prev;
      default: edges = s2 ^ d_prev;
    endcase
  end

  always_comb begin
    clr = '0;
    if (wr && address == 2'd3)
      clr = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    unique case (address)
      2'd0:    rd_mux[WIDTH-1:0] = s2;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  assign irq_next = (IRQ_TYPE == 1) ? |(edge_capture & irq_mask)
                                    : |(s2 & irq_mask);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1           <= '0;
      s2           <= '0;
      d_prev       <= '0;
      edge_capture <= '0;
      irq_mask     <= MASK_RST;
      readdata     <= '0;
      irq          <= 1'b0;
    end else begin
      s1       <= in_port;
      s2       <= s1;
      d_prev   <= s2;
      // a new edge wins over a same-cycle clear
      edge_capture <= (edge_capture & ~clr) | edges;
      if (wr && address == 2'd2)
        irq_mask <= writedata[WIDTH-1:0];
      readdata <= rd_mux;
      irq      <= irq_next;
    end
  end

endmodule

// File: tb/tb_present_core_pio_status_in.sv
// Directed bench for present_core_pio_status_in.
// Four instances: rising/edge-irq, falling (8-bit), any-edge, level-irq.
module tb_present_core_pio_status_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;

  logic [31:0] rd0, rd1, rd2, rdl;
  logic        irq0, irq1, irq2, irql;

  int n_chk;
  int n_fail;

  present_core_pio_status_in #(.WIDTH(32), .EDGE_TYPE(0), .IRQ_TYPE(1)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd0), .irq(irq0));

  present_core_pio_status_in #(.WIDTH(8), .EDGE_TYPE(1), .IRQ_TYPE(1)) u1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .in_port(in_port[7:0]), .readdata(rd1), .irq(irq1));

  present_core_pio_status_in #(.WIDTH(32), .EDGE_TYPE(2), .IRQ_TYPE(1)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rd2), .irq(irq2));

  present_core_pio_status_in #(.WIDTH(32), .EDGE_TYPE(0), .IRQ_TYPE(0)) ul (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .in_port(in_port), .readdata(rdl), .irq(irql));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    step(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a);
    address = a;
    step(1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_port    = 32'hFFFF_FFFF;

    // reset with inputs high
    step(3);
    check("rst_rd", rd0, 32'h0);
    check("rst_irq", {31'h0, irq0}, 32'h0);
    reset_n = 1'b1;
    step(2);
    check("sync_lat_2", rd0, 32'h0);
    step(1);
    check("sync_lat_3", rd0, 32'hFFFF_FFFF);
    check("zext_w8", rd1, 32'h0000_00FF);
    rd(2'd3);
    check("first_rise", rd0, 32'hFFFF_FFFF);

    // drop inputs, flush all captures
    in_port = 32'h0;
    step(4);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3);
    check("clr_all_u0", rd0, 32'h0);
    check("clr_all_u1", rd1, 32'h0);
    check("clr_all_u2", rd2, 32'h0);

    // one-cycle pulse on bit 0, mask bit 0
    wr(2'd2, 32'h1);
    in_port = 32'h1;
    step(1);
    in_port = 32'h0;
    step(3);
    rd(2'd3);
    check("pulse_cap", rd0, 32'h1);
    check("pulse_irq", {31'h0, irq0}, 32'h1);
    wr(2'd3, 32'h1);
    check("clr_irq_hold", {31'h0, irq0}, 32'h1);
    rd(2'd3);
    check("clr_cap", rd0, 32'h0);
    check("clr_irq", {31'h0, irq0}, 32'h0);

    // edge on bit 4 in the same cycle as its clear
    in_port = 32'h10;
    step(2);
    wr(2'd3, 32'h10);
    rd(2'd3);
    check("set_wins", rd0, 32'h10);
    check("unmasked_irq", {31'h0, irq0}, 32'h0);

    // mask gating on bit 7
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd2, 32'h0);
    in_port = 32'h90;
    step(4);
    check("masked_irq", {31'h0, irq0}, 32'h0);
    rd(2'd3);
    check("masked_cap", rd0, 32'h80);
    wr(2'd2, 32'h80);
    check("unmask_irq_1", {31'h0, irq0}, 32'h0);
    step(1);
    check("unmask_irq_2", {31'h0, irq0}, 32'h1);

    // any-edge vs falling-only on bit 3
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h98;
    step(4);
    rd(2'd3);
    check("any_rise", rd2, 32'h8);
    check("fall_no_rise", rd1, 32'h0);
    wr(2'd3, 32'h8);
    in_port = 32'h90;
    step(4);
    rd(2'd3);
    check("any_fall", rd2, 32'h8);
    check("fall_fall", rd1, 32'h8);
    check("rise_no_fall", rd0, 32'h0);

    // level irq on bit 1
    wr(2'd2, 32'h2);
    in_port = 32'h92;
    step(2);
    check("lvl_hi_2", {31'h0, irql}, 32'h0);
    step(1);
    check("lvl_hi_3", {31'h0, irql}, 32'h1);
    in_port = 32'h90;
    step(2);
    check("lvl_lo_2", {31'h0, irql}, 32'h1);
    step(1);
    check("lvl_lo_3", {31'h0, irql}, 32'h0);

    // async reset discards pending capture
    check("pend_irq", {31'h0, irq0}, 32'h1);
    reset_n = 1'b0;
    #2;
    check("async_irq", {31'h0, irq0}, 32'h0);
    check("async_rd", rd0, 32'h0);
    step(1);
    reset_n = 1'b1;
    rd(2'd3);
    check("rst_cap", rd0, 32'h0);
    rd(2'd2);
    check("rst_mask", rd0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
